// File: rtl/rca_chunk_seq.sv
// Multi-cycle wide adder: one N-bit ripple-carry pass per cycle, carry held between chunks.
// Optional early termination when the remaining operand chunks and the carry are all zero:
// define RCA_SEQ_EARLY_DONE_EN to enable it.

module rca_n #(
    parameter int n = 16
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         c_in,
    output logic [n-1:0] s,
    output logic         c_out
);

    // NOTE: a block-local variable with blocking assignments models the ripple
    // chain inside one process, so no feedback appears between separate nets.
    always_comb begin : ripple
        logic carry;
        carry = c_in;
        for (int i = 0; i < n; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

module rca_chunk_seq #(
    parameter int W      = 64,
    parameter int N      = 16,
    parameter int CHUNKS = W / N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         busy
);

    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               c_out_q, c_out_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [N-1:0]       add_s;
    logic               add_co;

    // The adder always sees the lowest chunk; operands shift down after each pass.
    rca_n #(.n(N)) u_rca (
        .a     (a_q[N-1:0]),
        .b     (b_q[N-1:0]),
        .c_in  (carry_q),
        .s     (add_s),
        .c_out (add_co)
    );

    // NOTE: every *_d gets its hold value first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[int'(idx_q) * N +: N] = add_s;
                carry_d = add_co;
                a_d     = a_q >> N;
                b_d     = b_q >> N;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    c_out_d = add_co;
                end
`ifdef RCA_SEQ_EARLY_DONE_EN
                // Untouched upper chunks of sum_q are already zero, so stopping here stays exact.
                else if ((a_d == '0) && (b_d == '0) && !add_co) begin
                    state_d = S_DONE;
                    c_out_d = 1'b0;
                end
`endif
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge value regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;

endmodule

// File: tb/tb_rca_chunk_seq.sv
// Self-checking bench for rca_chunk_seq: a 64/16 instance and a 16/16 (single chunk) instance,
// compared against an arithmetic reference model of sum and latency.

module tb_rca_chunk_seq;

`ifdef RCA_SEQ_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, busy;
    logic [63:0] a, b, sum;

    logic        in_valid_s, in_ready_s, c_in_s, out_valid_s, out_ready_s, c_out_s, busy_s;
    logic [15:0] a_s, b_s, sum_s;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    rca_chunk_seq #(.W(64), .N(16)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .busy      (busy)
    );

    rca_chunk_seq #(.W(16), .N(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s),
        .in_ready  (in_ready_s),
        .a         (a_s),
        .b         (b_s),
        .c_in      (c_in_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready_s),
        .sum       (sum_s),
        .c_out     (c_out_s),
        .busy      (busy_s)
    );

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic logic [64:0] ref_sum(input logic [63:0] x, input logic [63:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + 65'(ci);
    endfunction

    // Cycles from the accept edge (counted as 1) until out_valid is seen.
    function automatic int ref_lat(input logic [63:0] x, input logic [63:0] y, input logic ci);
        logic [64:0] mask, part, xe, ye;
        int unsigned w;
        xe = {1'b0, x};
        ye = {1'b0, y};
        for (int j = 0; j < 3; j++) begin
            w    = 32'(j + 1) * 16;
            mask = (65'd1 << w) - 65'd1;
            part = (xe & mask) + (ye & mask) + 65'(ci);
            if (EARLY && ((part >> w) == 65'd0) && ((xe >> w) == 65'd0) && ((ye >> w) == 65'd0))
                return j + 2;
        end
        return 5;
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        int          n;
        v = {$urandom, $urandom};
        n = $urandom_range(1, 4);
        if (n < 4) v = v & ((64'd1 << (16 * n)) - 64'd1);
        if ($urandom_range(0, 7) == 0) v[15:0] = 16'hFFFF;
        return v;
    endfunction

    task automatic run64(input logic [63:0] x, input logic [63:0] y, input logic ci, output int lat);
        a        = x;
        b        = y;
        c_in     = ci;
        in_valid = 1'b1;
        check("accept_ready", 65'(in_ready), 65'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    initial begin
        logic [64:0] exp;
        logic [63:0] cur_a, cur_b, nxt_a, nxt_b;
        logic        cur_c, nxt_c;
        logic [15:0] xs, ys;
        logic        cs;
        int          lat, el, acc, prev_acc, prev_lat;

        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
        in_valid_s = 1'b0; a_s = '0; b_s = '0; c_in_s = 1'b0; out_ready_s = 1'b1;
        #2;

        // Reset values
        check("rst_in_ready", 65'(in_ready), 65'd1);
        check("rst_out_valid", 65'(out_valid), 65'd0);
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_sum", 65'(sum), 65'd0);
        check("rst_c_out", 65'(c_out), 65'd0);
        check("rst16_in_ready", 65'(in_ready_s), 65'd1);
        check("rst16_out_valid", 65'(out_valid_s), 65'd0);
        check("rst16_sum", 65'(sum_s), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_after_rst", 65'(busy), 65'd0);

        // Full carry ripple
        run64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
        check("ripple_lat", 65'(lat), 65'd5);
        check("ripple_sum", 65'(sum), 65'd0);
        check("ripple_c_out", 65'(c_out), 65'd1);
        check("ripple_busy", 65'(busy), 65'd1);
        check("ripple_no_ready", 65'(in_ready), 65'd0);
        step();
        check("ripple_valid_1cyc", 65'(out_valid), 65'd0);
        check("ripple_ready_back", 65'(in_ready), 65'd1);

        // Small operands
        run64(64'h1234, 64'h1, 1'b1, lat);
        check("small_lat", 65'(lat), EARLY ? 65'd2 : 65'd5);
        check("small_sum", 65'(sum), 65'h1236);
        check("small_c_out", 65'(c_out), 65'd0);
        step();
        check("small_ready_back", 65'(in_ready), 65'd1);

        // Backpressure
        out_ready = 1'b0;
        cur_a = rand_op(); cur_b = rand_op(); cur_c = 1'($urandom_range(0, 1));
        exp = ref_sum(cur_a, cur_b, cur_c);
        run64(cur_a, cur_b, cur_c, lat);
        check("bp_lat", 65'(lat), 65'(ref_lat(cur_a, cur_b, cur_c)));
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = 1'b1;
            in_valid = 1'b1;
            step();
            check("bp_valid_held", 65'(out_valid), 65'd1);
            check("bp_in_ready", 65'(in_ready), 65'd0);
            check("bp_result_stable", {c_out, sum}, exp);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_idle", 65'(in_ready), 65'd1);
        check("bp_release_valid", 65'(out_valid), 65'd0);
        step();
        check("bp_ignored_no_start", 65'(busy), 65'd0);

        // Reset in the middle of RUN
        a = 64'h1111_2222_3333_4444; b = 64'h0101_0202_0303_0404; c_in = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid_busy", 65'(busy), 65'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 65'(out_valid), 65'd0);
        check("mid_rst_in_ready", 65'(in_ready), 65'd1);
        check("mid_rst_sum", 65'(sum), 65'd0);
        check("mid_rst_busy", 65'(busy), 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("mid_no_emit", 65'(out_valid), 65'd0);
        end

        // Back-to-back random traffic with in_valid held high
        out_ready = 1'b1;
        cur_a = rand_op(); cur_b = rand_op(); cur_c = 1'($urandom_range(0, 1));
        a = cur_a; b = cur_b; c_in = cur_c; in_valid = 1'b1;
        prev_acc = 0; prev_lat = 0;
        for (int t = 0; t < 1000; t++) begin
            check("b2b_ready", 65'(in_ready), 65'd1);
            step();
            acc = cycle;
            if (t > 0) check("b2b_interval", 65'(acc - prev_acc), 65'(prev_lat + 1));
            exp = ref_sum(cur_a, cur_b, cur_c);
            el  = ref_lat(cur_a, cur_b, cur_c);
            nxt_a = rand_op(); nxt_b = rand_op(); nxt_c = 1'($urandom_range(0, 1));
            a = nxt_a; b = nxt_b; c_in = nxt_c;
            lat = 1;
            while (!out_valid && lat < 20) begin
                step();
                lat++;
            end
            check("b2b_lat", 65'(lat), 65'(el));
            check("b2b_result", {c_out, sum}, exp);
            step();
            prev_acc = acc; prev_lat = el;
            cur_a = nxt_a; cur_b = nxt_b; cur_c = nxt_c;
        end
        in_valid = 1'b0;
        step();

        // Single-chunk configuration
        xs = 16'h8000; ys = 16'h8000; cs = 1'b0;
        for (int t = 0; t < 21; t++) begin
            a_s = xs; b_s = ys; c_in_s = cs;
            in_valid_s = 1'b1;
            check("c1_accept_ready", 65'(in_ready_s), 65'd1);
            step();
            in_valid_s = 1'b0;
            lat = 1;
            while (!out_valid_s && lat < 20) begin
                step();
                lat++;
            end
            check("c1_lat", 65'(lat), 65'd2);
            check("c1_result", {48'd0, c_out_s, sum_s}, 65'({1'b0, xs} + {1'b0, ys} + 17'(cs)));
            step();
            check("c1_ready_back", 65'(in_ready_s), 65'd1);
            xs = 16'($urandom); ys = 16'($urandom); cs = 1'($urandom_range(0, 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rca_chunk_seq.md
# rca_chunk_seq

Multi-cycle wide-addition sequencer for the approximate ALU. Computes a W-bit sum using one N-bit `rca_n` instance, one chunk per cycle, with the inter-chunk carry held in a register. Trades latency for area on wide operands. Sits between the ALU operand issue stage and the result writeback, with valid/ready handshakes on both sides.

## Interface

Parameters:
- `W`, default 64: total operand width. Must be a multiple of `N`.
- `N`, default 16: chunk width, passed to the internal `rca_n` as `n`.
- `CHUNKS`, derived as W/N: number of adder passes. Must be ≥1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands `a`, `b` and `c_in` are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `c_in`  in  1  carry into chunk 0.
- `out_valid`  out  1  `sum` and `c_out` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  W  registered result.
- `c_out`  out  1  carry out of the top chunk.
- `busy`  out  1  high in RUN or DONE.

## Operation

- FSM states: IDLE, RUN, DONE. Output decode is registered-state only; there is no combinational input-to-output path.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, the block loads:
    - `a_reg`←`a`, `b_reg`←`b`, `carry`←`c_in`;
    - `sum_reg`←0, `idx`←0.
  - Next state is RUN.
- **RUN:** the adder inputs are `a_reg[N-1:0]`, `b_reg[N-1:0]` and `carry`. Each cycle:
  - `sum_reg[idx*N +: N]`←adder sum;
  - `carry`←adder carry-out;
  - `a_reg`, `b_reg` shift right by N with zero fill;
  - `idx`++.
  - When `idx`==CHUNKS-1, next state is DONE and `c_out`←adder carry-out.
- **DONE:**
  - `out_valid`=1; `sum`=`sum_reg`.
  - On `out_ready`, next state is IDLE.
  - Results stay stable while `out_ready`=0.
- `in_valid` is ignored outside IDLE. No operand buffering.
- Arithmetic is modulo 2^W plus `c_out`, i.e. {`c_out`,`sum`} = `a`+`b`+`c_in` exactly (unless the feature below is enabled and fires, which is still exact).
- `idx` is ceil(log2(CHUNKS)) bits wide, minimum 1. For CHUNKS=1, RUN lasts exactly one cycle.
- Reset mid-operation: the in-flight operation is discarded, nothing is emitted, and the block returns to IDLE.

## Timing

- Reset values:
  - state IDLE;
  - `in_ready`=1 (as IDLE decode), `out_valid`=0, `busy`=0;
  - `sum`=0, `c_out`=0;
  - all internal registers 0.
- Accept edge at T0. RUN occupies cycles T0+1 … T0+CHUNKS. `out_valid` rises after edge T0+CHUNKS.
- Latency: CHUNKS+1 cycles from accept to `out_valid`.
- With `out_ready` held high, `out_valid` is high for exactly 1 cycle. `in_ready` returns the cycle after the output handshake.
- Minimum initiation interval: CHUNKS+2 cycles.
- `in_ready` and `out_valid` are never high in the same cycle.

## Configuration

- Macro: `RCA_SEQ_EARLY_DONE_EN`.
- **Defined:** in RUN, after writing the current chunk, the block tests three conditions:
  - the shifted-in `a_reg` upper bits are all zero;
  - the shifted-in `b_reg` upper bits are all zero;
  - the current adder carry-out is 0.

  If all three hold, it goes to DONE immediately with `c_out`=0. The remaining chunks are already 0 in `sum_reg`, so the result stays exact and latency shrinks to k+1 cycles, where k is the chunks consumed.
- **Undefined:** RUN always lasts CHUNKS cycles. The early-exit logic is absent.

## Test plan

All scenarios use W=64, N=16.

1. **Reset:** assert `rst_n`=0 mid-RUN.
   - Required: `out_valid`=0, `in_ready`=1, `sum`=0 immediately.
   - No result is emitted after `rst_n` releases.
2. **Full carry ripple:** `a`=64'hFFFF_FFFF_FFFF_FFFF, `b`=1, `c_in`=0.
   - Required: `sum`=0, `c_out`=1.
   - `out_valid` appears 5 cycles after accept (early-done does not fire because the carry propagates).
3. **Small operands:** `a`=64'h0000_0000_0000_1234, `b`=64'h0000_0000_0000_0001, `c_in`=1.
   - Required: `sum`=64'h1236, `c_out`=0.
   - Latency 5 cycles without the macro, 2 cycles with `RCA_SEQ_EARLY_DONE_EN`.
4. **Backpressure:**
   - Hold `out_ready`=0 for 10 cycles in DONE. Required: `sum`/`c_out` stable, `in_ready`=0, and `in_valid` with new operands is ignored.
   - Then raise `out_ready`. Required: IDLE on the next cycle.
5. **Back-to-back:** 1000 random operand sets with `out_ready`=1.
   - Required: {`c_out`,`sum`} matches the reference sum for every set.
   - Initiation interval is 6 cycles without the macro.
6. **Boundary configuration:** parameters W=16, N=16 (CHUNKS=1), `a`=16'h8000, `b`=16'h8000.
   - Required: `sum`=0, `c_out`=1, latency 2 cycles.
